input_snapshot_ctrl: RTL

Sequences a once-per-frame copy of the live controller/input state into the core's shared system RAM, and arbitrates that RAM's single port between the copy engine and the soc CPU. Sits between hps_io (input words), the video timing (vblank) and the soc RAM port. It drives `LED_USER` through `copy_in_progress`. The copy is coherent: all words come from the same instant.

---
 rtl/input_snapshot_ctrl_pkg.sv | 19 +
 rtl/input_snapshot_ctrl_if.sv | 30 +++
 rtl/input_snapshot_ctrl_arb.sv | 39 +++
 rtl/input_snapshot_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/input_snapshot_ctrl_pkg.sv
// Shared types and defaults for the input snapshot controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package input_test_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } snap_state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_COPY = 1'b1
    } owner_t;

    localparam int          DEF_NUM_WORDS = 16;
    localparam logic [15:0] DEF_BASE_ADDR = 16'h8000;

endpackage

// File: rtl/input_snapshot_ctrl_if.sv
// CPU request/ack bus and synchronous single-port RAM bus.
// Latency: n/a (wiring only); RAM read data arrives one cycle after the address.
// Backpressure: CPU holds cpu_req until a one-cycle cpu_ack; the RAM never stalls.
interface snap_cpu_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_dout;

    modport master (output cpu_req, cpu_we, cpu_addr, cpu_din, input cpu_ack, cpu_dout);
    modport slave  (input cpu_req, cpu_we, cpu_addr, cpu_din, output cpu_ack, cpu_dout);
endinterface

interface snap_ram_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (output ram_addr, ram_we, ram_din, input ram_dout);
    modport slave  (input ram_addr, ram_we, ram_din, output ram_dout);
endinterface

// File: rtl/input_snapshot_ctrl_arb.sv
// Two-requester round-robin arbiter (CPU vs copy engine) for the RAM port.
// Latency: combinational grant in the request cycle; last_winner updates at the edge.
// Backpressure: a requester that loses a conflict wins the next one.
// Ports: clk_sys/reset_n, req_cpu/req_copy in, gnt_cpu/gnt_copy out (one-hot or none).
module arb_rr2
    import input_test_pkg::*;
(
    input  logic clk_sys,
    input  logic reset_n,
    input  logic req_cpu,
    input  logic req_copy,
    output logic gnt_cpu,
    output logic gnt_copy
);

    owner_t last_winner;
    logic   conflict;

    always_comb begin
        conflict = req_cpu & req_copy;
        gnt_cpu  = 1'b0;
        gnt_copy = 1'b0;
        if (conflict) begin
            // Loser of the previous conflict takes this one.
            if (last_winner == OWN_CPU) gnt_copy = 1'b1;
            else                        gnt_cpu  = 1'b1;
        end else begin
            gnt_cpu  = req_cpu;
            gnt_copy = req_copy;
        end
    end

    // Only contested cycles move the fairness pointer; reset favours the copy first.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)      last_winner <= OWN_CPU;
        else if (conflict) last_winner <= gnt_copy ? OWN_COPY : OWN_CPU;
    end

endmodule

// File: rtl/input_snapshot_ctrl.sv
// Latches input_bus on a vblank rising edge and copies it word by word into RAM, sharing the port with the CPU.
// Latency: copy starts the cycle after the trigger edge, 1 word/cycle uncontested; CPU ack one cycle after grant.
// Backpressure: CPU req held until ack; on conflict copy and CPU alternate wins (round-robin).
// Ports: clk_sys, reset_n, vblank, input_bus, cpu (slave), ram (master), copy_in_progress, copy_done.
module input_snapshot_ctrl
    import input_test_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter int                NUM_WORDS = DEF_NUM_WORDS,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR)
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic                        vblank,
    input  logic [NUM_WORDS*DATA_W-1:0] input_bus,
    snap_cpu_if.slave                   cpu,
    snap_ram_if.master                  ram,
    output logic                        copy_in_progress,
    output logic                        copy_done
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    snap_state_t       state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] snap [NUM_WORDS];
    logic              vblank_q;
    logic              vblank_rise;
    logic              cpu_ack_q;
    logic              copy_req, cpu_req_eff;
    logic              gnt_cpu, gnt_copy;
    logic              last_gnt;
    logic [ADDR_W-1:0] copy_addr;
    logic [ADDR_W-1:0] addr_c, addr_q;
    logic [DATA_W-1:0] din_c, din_q;
    logic              we_c;

    assign vblank_rise = vblank & ~vblank_q;
    // A request seen during its own ack cycle is stale and must not be re-granted.
    assign cpu_req_eff = cpu.cpu_req & ~cpu_ack_q;
    assign copy_addr   = BASE_ADDR + ADDR_W'(idx);
    assign last_gnt    = gnt_copy && (idx == IDX_W'(NUM_WORDS - 1));

    arb_rr2 u_arb (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .req_cpu  (cpu_req_eff),
        .req_copy (copy_req),
        .gnt_cpu  (gnt_cpu),
        .gnt_copy (gnt_copy)
    );

    // FSM state register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vblank_rise) state_nxt = COPY;
            COPY:    if (last_gnt)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        copy_req         = (state == COPY);
        copy_in_progress = (state == COPY);
    end

    // Snapshot, index and edge detector. vblank_q resets high so a vblank
    // already asserted at reset release is not mistaken for a new frame.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q <= 1'b1;
            idx      <= '0;
            for (int i = 0; i < NUM_WORDS; i++) snap[i] <= '0;
        end else begin
            vblank_q <= vblank;
            if (state == IDLE && vblank_rise) begin
                idx <= '0;
                for (int i = 0; i < NUM_WORDS; i++) snap[i] <= input_bus[i*DATA_W +: DATA_W];
            end else if (gnt_copy) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // RAM port mux: address/data hold their last value when nobody is granted.
    always_comb begin
        addr_c = addr_q;
        din_c  = din_q;
        we_c   = 1'b0;
        if (gnt_copy) begin
            addr_c = copy_addr;
            din_c  = snap[idx];
            we_c   = 1'b1;
        end else if (gnt_cpu) begin
            addr_c = cpu.cpu_addr;
            din_c  = cpu.cpu_din;
            we_c   = cpu.cpu_we;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            din_q     <= '0;
            cpu_ack_q <= 1'b0;
            copy_done <= 1'b0;
        end else begin
            addr_q    <= addr_c;
            din_q     <= din_c;
            cpu_ack_q <= gnt_cpu;
            copy_done <= last_gnt;
        end
    end

    assign ram.ram_addr = addr_c;
    assign ram.ram_din  = din_c;
    assign ram.ram_we   = we_c;
    assign cpu.cpu_ack  = cpu_ack_q;
    assign cpu.cpu_dout = cpu_ack_q ? ram.ram_dout : '0;

endmodule
